// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined NxN Urdhva-Tiryagbhyam multiplier with valid/ready handshake and per-operation signed mode.
// Optional transfer counter (op_count / op_count_clr) is built only when VEDIC_MULT_OPCNT_EN is defined.

module vedic_mul_core #(
    parameter int W = 2
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    generate
        if (W == 2) begin : g_cell
            // 2x2 leaf: partial-product ANDs folded with two half adders
            logic pp00, pp01, pp10, pp11, c1;
            assign pp00 = a[0] & b[0];
            assign pp10 = a[1] & b[0];
            assign pp01 = a[0] & b[1];
            assign pp11 = a[1] & b[1];
            assign c1   = pp10 & pp01;
            assign p[0] = pp00;
            assign p[1] = pp10 ^ pp01;
            assign p[2] = pp11 ^ c1;
            assign p[3] = pp11 & c1;
        end else begin : g_split
            localparam int H = W / 2;
            logic [W-1:0] ll, hl, lh, hh;
            logic [W:0]   mid;

            vedic_mul_core #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
            vedic_mul_core #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
            vedic_mul_core #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
            vedic_mul_core #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));

            // Vertical terms sit side by side; the crosswise sum is added at the half offset
            assign mid = {1'b0, hl} + {1'b0, lh};
            assign p   = {hh, ll} + ({{(W-1){1'b0}}, mid} << H);
        end
    endgenerate
endmodule

module vedic_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] p,
`ifdef VEDIC_MULT_OPCNT_EN
    output logic [15:0]      op_count,
    input  logic             op_count_clr,
`endif
    output logic             p_signed
);
    localparam int H = WIDTH / 2;

    generate
        if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0) || (OUT_W != 2 * WIDTH)) begin : g_bad_param
            $error("vedic_mult_pipe: WIDTH must be a power of two >= 4 and OUT_W must equal 2*WIDTH");
        end
    endgenerate

    // Stage 1: magnitudes and sign
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_mag_a_q, s1_mag_a_d;
    logic [WIDTH-1:0] s1_mag_b_q, s1_mag_b_d;
    logic             s1_neg_q, s1_neg_d;
    logic             s1_smode_q, s1_smode_d;

    // Stage 2: sub-products, index = {b_half, a_half}
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_sub_q [4];
    logic [WIDTH-1:0] s2_sub_d [4];
    logic             s2_neg_q, s2_neg_d;
    logic             s2_smode_q, s2_smode_d;

    // Stage 3: final product
    logic             s3_valid_q, s3_valid_d;
    logic [OUT_W-1:0] s3_p_q, s3_p_d;
    logic             s3_smode_q, s3_smode_d;

    logic             advance;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] sub_prod [4];
    logic [OUT_W:0]   sum_ext;
    logic [WIDTH:0]   cross_sum;

    assign advance  = !(s3_valid_q && !out_ready);
    assign in_ready = advance;

    assign abs_a = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign abs_b = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub
            vedic_mul_core #(.W(H)) u_sub (
                .a(s1_mag_a_q[(gi % 2) * H +: H]),
                .b(s1_mag_b_q[(gi / 2) * H +: H]),
                .p(sub_prod[gi])
            );
        end
    endgenerate

    // Index 0 = LL, 1 = HL (aH*bL), 2 = LH (aL*bH), 3 = HH
    assign cross_sum = {1'b0, s2_sub_q[1]} + {1'b0, s2_sub_q[2]};
    assign sum_ext   = {1'b0, s2_sub_q[3], s2_sub_q[0]}
                     + ({{WIDTH{1'b0}}, cross_sum} << H);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mag_a_d = s1_mag_a_q;
        s1_mag_b_d = s1_mag_b_q;
        s1_neg_d   = s1_neg_q;
        s1_smode_d = s1_smode_q;
        s2_valid_d = s2_valid_q;
        s2_neg_d   = s2_neg_q;
        s2_smode_d = s2_smode_q;
        for (int i = 0; i < 4; i++) begin
            s2_sub_d[i] = s2_sub_q[i];
        end
        s3_valid_d = s3_valid_q;
        s3_p_d     = s3_p_q;
        s3_smode_d = s3_smode_q;

        if (advance) begin
            s1_valid_d = in_valid;
            s2_valid_d = s1_valid_q;
            s3_valid_d = s2_valid_q;
            // Payloads only move with a valid token so p never shows bubble data
            if (in_valid) begin
                s1_mag_a_d = abs_a;
                s1_mag_b_d = abs_b;
                s1_neg_d   = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
                s1_smode_d = signed_mode;
            end
            if (s1_valid_q) begin
                for (int i = 0; i < 4; i++) begin
                    s2_sub_d[i] = sub_prod[i];
                end
                s2_neg_d   = s1_neg_q;
                s2_smode_d = s1_smode_q;
            end
            if (s2_valid_q) begin
                s3_p_d     = OUT_W'(s2_neg_q ? (~sum_ext + (OUT_W+1)'(1)) : sum_ext);
                s3_smode_d = s2_smode_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mag_a_q <= '0;
            s1_mag_b_q <= '0;
            s1_neg_q   <= 1'b0;
            s1_smode_q <= 1'b0;
            s2_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s2_sub_q[i] <= '0;
            end
            s2_neg_q   <= 1'b0;
            s2_smode_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_p_q     <= '0;
            s3_smode_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mag_a_q <= s1_mag_a_d;
            s1_mag_b_q <= s1_mag_b_d;
            s1_neg_q   <= s1_neg_d;
            s1_smode_q <= s1_smode_d;
            s2_valid_q <= s2_valid_d;
            for (int i = 0; i < 4; i++) begin
                s2_sub_q[i] <= s2_sub_d[i];
            end
            s2_neg_q   <= s2_neg_d;
            s2_smode_q <= s2_smode_d;
            s3_valid_q <= s3_valid_d;
            s3_p_q     <= s3_p_d;
            s3_smode_q <= s3_smode_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign p         = s3_p_q;
    assign p_signed  = s3_smode_q;

`ifdef VEDIC_MULT_OPCNT_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (op_count_clr) begin
            op_count_d = 16'h0000;
        end else if (s3_valid_q && out_ready && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'h0001;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q <= 16'h0000;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Directed bench for vedic_mult_pipe (WIDTH=8): latency, signed/unsigned products, streaming, backpressure, reset.
// Counter checks are compiled in when VEDIC_MULT_OPCNT_EN is defined.

module tb_vedic_mult_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        p_signed;
`ifdef VEDIC_MULT_OPCNT_EN
    logic [15:0] op_count;
    logic        op_count_clr;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vedic_mult_pipe #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .p           (p),
`ifdef VEDIC_MULT_OPCNT_EN
        .op_count    (op_count),
        .op_count_clr(op_count_clr),
`endif
        .p_signed    (p_signed)
    );

    logic [7:0] va [20] = '{8'h00, 8'h01, 8'hFF, 8'h7F, 8'h80, 8'h80, 8'h12, 8'hAB, 8'hAB, 8'h55,
                            8'hF0, 8'hF0, 8'h0F, 8'h3C, 8'hC3, 8'h80, 8'hFF, 8'h02, 8'h00, 8'h9D};
    logic [7:0] vb [20] = '{8'h00, 8'hFF, 8'h01, 8'h7F, 8'h7F, 8'h01, 8'h34, 8'hCD, 8'hCD, 8'hAA,
                            8'h0F, 8'h0F, 8'hF0, 8'hC3, 8'h3C, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h61};
    logic       vs [20] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                            1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic [15:0] ex, ey;
        ex = s ? {{8{x[7]}}, x} : {8'h00, x};
        ey = s ? {{8{y[7]}}, y} : {8'h00, y};
        return ex * ey;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic s);
        in_valid    = 1'b1;
        a           = x;
        b           = y;
        signed_mode = s;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
`ifdef VEDIC_MULT_OPCNT_EN
        op_count_clr = 1'b0;
`endif
        repeat (2) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (p !== 16'h0000) begin bad++; $display("FAIL reset_p got=%h want=0000", p); end
        total++; if (p_signed !== 1'b0) begin bad++; $display("FAIL reset_p_signed got=%b want=0", p_signed); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
        $display("test_reset: done");
    endtask

    task automatic test_unsigned_max();
        drive(8'hFF, 8'hFF, 1'b0);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_c1 out_valid got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_c2 out_valid got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_c3 out_valid got=%b want=1", out_valid); end
        total++; if (p !== 16'hFE01) begin bad++; $display("FAIL umax_p got=%h want=fe01", p); end
        total++; if (p_signed !== 1'b0) begin bad++; $display("FAIL umax_p_signed got=%b want=0", p_signed); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_c4 out_valid got=%b want=0", out_valid); end
        $display("test_unsigned_max: a=ff b=ff p=%h", 16'hFE01);
    endtask

    task automatic test_signed();
        logic [7:0]  ta [4] = '{8'h80, 8'hFF, 8'h00, 8'h80};
        logic [7:0]  tb [4] = '{8'h80, 8'h7F, 8'h80, 8'h80};
        logic        ts [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] te [4] = '{16'h4000, 16'hFF81, 16'h0000, 16'h4000};
        for (int i = 0; i < 4; i++) begin
            drive(ta[i], tb[i], ts[i]);
            tick();
            in_valid = 1'b0;
            repeat (2) tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL signed_valid[%0d] got=%b want=1", i, out_valid); end
            total++; if (p !== te[i]) begin bad++; $display("FAIL signed_p[%0d] got=%h want=%h", i, p, te[i]); end
            total++; if (p_signed !== ts[i]) begin bad++; $display("FAIL signed_flag[%0d] got=%b want=%b", i, p_signed, ts[i]); end
            $display("test_signed: a=%h b=%h s=%b want=%h", ta[i], tb[i], ts[i], te[i]);
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_p;
        for (int i = 0; i < 23; i++) begin
            if (i < 20) drive(va[i], vb[i], vs[i]);
            else in_valid = 1'b0;
            tick();
            if (i >= 2 && i < 22) begin
                exp_p = ref_mul(va[i-2], vb[i-2], vs[i-2]);
                total++;
                if (out_valid !== 1'b1 || p !== exp_p || p_signed !== vs[i-2]) begin
                    bad++;
                    $display("FAIL stream[%0d] got v=%b p=%h s=%b want v=1 p=%h s=%b",
                             i - 2, out_valid, p, p_signed, exp_p, vs[i-2]);
                end else begin
                    $display("stream[%0d]: a=%h b=%h s=%b p=%h", i - 2, va[i-2], vb[i-2], vs[i-2], p);
                end
            end else begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_idle[%0d] out_valid got=%b want=0", i, out_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] ba [3] = '{8'h0C, 8'h90, 8'h7F};
        logic [7:0] bb [3] = '{8'h0D, 8'h10, 8'h81};
        logic       bs [3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] be [3];
        int k;
        for (int i = 0; i < 3; i++) be[i] = ref_mul(ba[i], bb[i], bs[i]);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(ba[i], bb[i], bs[i]);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_fill_ready[%0d] got=%b want=1", i, in_ready); end
            tick();
        end
        // Offer an extra pair while stalled; it must not be taken
        drive(8'h33, 8'h03, 1'b0);
        for (int c = 0; c < 4; c++) begin
            total++;
            if (out_valid !== 1'b1 || p !== be[0] || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d] got v=%b p=%h rdy=%b want v=1 p=%h rdy=0", c, out_valid, p, in_ready, be[0]);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid === 1'b1) begin
                total++;
                if (k >= 3) begin
                    bad++; $display("FAIL bp_extra[%0d] got p=%h want no result", k, p);
                end else if (p !== be[k] || p_signed !== bs[k]) begin
                    bad++; $display("FAIL bp_drain[%0d] got p=%h s=%b want p=%h s=%b", k, p, p_signed, be[k], bs[k]);
                end else begin
                    $display("bp_drain[%0d]: p=%h", k, p);
                end
                k++;
            end
            tick();
        end
        total++; if (k != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", k); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        drive(8'h21, 8'h22, 1'b0); tick();
        drive(8'h31, 8'h32, 1'b0); tick();
        drive(8'h41, 8'h42, 1'b0); tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%b want=1", out_valid); end
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
        total++; if (p !== 16'h0000) begin bad++; $display("FAIL midrst_p got=%h want=0000", p); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", in_ready); end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale[%0d] got=%b want=0", c, out_valid); end
        end
        drive(8'h0B, 8'h0B, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_early got=%b want=0", out_valid); end
        tick();
        total++;
        if (out_valid !== 1'b1 || p !== 16'h0079) begin
            bad++; $display("FAIL midrst_after got v=%b p=%h want v=1 p=0079", out_valid, p);
        end
        $display("test_reset_midflight: post-reset p=%h", p);
        tick();
    endtask

`ifdef VEDIC_MULT_OPCNT_EN
    task automatic test_op_count();
        out_ready = 1'b1;
        op_count_clr = 1'b1; tick(); op_count_clr = 1'b0;
        total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL opcnt_clr got=%h want=0000", op_count); end
        for (int i = 0; i < 5; i++) begin drive(8'(i), 8'h03, 1'b0); tick(); end
        in_valid = 1'b0;
        repeat (4) tick();
        total++; if (op_count !== 16'd5) begin bad++; $display("FAIL opcnt_five got=%h want=0005", op_count); end
        drive(8'h05, 8'h05, 1'b0); tick(); in_valid = 1'b0;
        repeat (2) tick();
        op_count_clr = 1'b1;
        tick();
        op_count_clr = 1'b0;
        total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL opcnt_clr_prio got=%h want=0000", op_count); end
        for (int i = 0; i < 65535; i++) begin drive(8'(i), 8'h01, 1'b0); tick(); end
        in_valid = 1'b0;
        repeat (4) tick();
        total++; if (op_count !== 16'hFFFF) begin bad++; $display("FAIL opcnt_full got=%h want=ffff", op_count); end
        drive(8'h01, 8'h01, 1'b0); tick(); in_valid = 1'b0;
        repeat (4) tick();
        total++; if (op_count !== 16'hFFFF) begin bad++; $display("FAIL opcnt_sat got=%h want=ffff", op_count); end
        $display("test_op_count: final=%h", op_count);
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef VEDIC_MULT_OPCNT_EN
        test_op_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
